// File: rtl/ascensor_ctrl_if.sv
// Bundle of the dispatcher's call, limit-switch and motor/status signals.
// The master side (plant/panel) drives calls and limits; the slave side (controller) drives the rest.
interface ascensor_ctrl_if #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
) ();
  logic [N_FLOORS-1:0] call_req;
  logic                top_lim;
  logic                bott_lim;
  logic                go_up;
  logic                go_down;
  logic                halt;
  logic [FLOOR_W-1:0]  floor;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  modport master (
    output call_req, top_lim, bott_lim,
    input  go_up, go_down, halt, floor, door_open, pending, busy
  );

  modport slave (
    input  call_req, top_lim, bott_lim,
    output go_up, go_down, halt, floor, door_open, pending, busy
  );
endinterface

// File: rtl/ascensor_ctrl.sv
// SCAN-order elevator dispatcher: latches floor calls, tracks the cabin by travel-time
// counting, drives one-hot motor commands and times the door.
module ascensor_ctrl #(
  parameter int N_FLOORS   = 4,
  parameter int FLOOR_W    = 2,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 4
) (
  input logic            CLK,
  input logic            RESET,
  ascensor_ctrl_if.slave bus
);
  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = $clog2(DOOR_CYC + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYC - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_up_q, dir_up_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] clr;
  logic [FLOOR_W-1:0]  floor_up, floor_dn;

  function automatic logic calls_above(input logic [N_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic calls_below(input logic [N_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  assign floor_up = floor_q + FLOOR_W'(1);
  assign floor_dn = floor_q - FLOOR_W'(1);

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    tcnt_d   = tcnt_q;
    dcnt_d   = dcnt_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (pending_q[floor_q]) begin
          state_d      = DOOR;
          clr[floor_q] = 1'b1;
        end else if (calls_above(pending_q, floor_q)) begin
          state_d  = UP;
          dir_up_d = 1'b1;
        end else if (calls_below(pending_q, floor_q)) begin
          state_d  = DOWN;
          dir_up_d = 1'b0;
        end
      end
      UP: begin
        // A limit switch overrides the travel count; top floor also saturates.
        if (bus.top_lim || floor_q == TOP_FLOOR) begin
          floor_d        = TOP_FLOOR;
          tcnt_d         = '0;
          dcnt_d         = '0;
          state_d        = DOOR;
          clr[TOP_FLOOR] = 1'b1;
        end else if (tcnt_q == TRAVEL_LAST) begin
          floor_d = floor_up;
          tcnt_d  = '0;
          if (pending_q[floor_up]) begin
            state_d       = DOOR;
            dcnt_d        = '0;
            clr[floor_up] = 1'b1;
          end else if (!calls_above(pending_q, floor_up)) begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DOWN: begin
        if (bus.bott_lim || floor_q == '0) begin
          floor_d = '0;
          tcnt_d  = '0;
          dcnt_d  = '0;
          state_d = DOOR;
          clr[0]  = 1'b1;
        end else if (tcnt_q == TRAVEL_LAST) begin
          floor_d = floor_dn;
          tcnt_d  = '0;
          if (pending_q[floor_dn]) begin
            state_d       = DOOR;
            dcnt_d        = '0;
            clr[floor_dn] = 1'b1;
          end else if (!calls_below(pending_q, floor_dn)) begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - tcnt_q + tcnt_q + TW'(1);
        end
      end
      DOOR: begin
        // A fresh call for this floor keeps the door open instead of latching.
        if (bus.call_req[floor_q]) begin
          dcnt_d       = '0;
          clr[floor_q] = 1'b1;
        end else if (dcnt_q == DOOR_LAST) begin
          dcnt_d = '0;
          if (dir_up_q && calls_above(pending_q, floor_q)) begin
            state_d = UP;
          end else if (!dir_up_q && calls_below(pending_q, floor_q)) begin
            state_d = DOWN;
          end else if (calls_above(pending_q, floor_q)) begin
            state_d  = UP;
            dir_up_d = 1'b1;
          end else if (calls_below(pending_q, floor_q)) begin
            state_d  = DOWN;
            dir_up_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | bus.call_req) & ~clr;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      pending_q <= pending_d;
    end
  end

  assign bus.go_up     = (state_q == UP);
  assign bus.go_down   = (state_q == DOWN);
  assign bus.halt      = (state_q == IDLE) || (state_q == DOOR);
  assign bus.door_open = (state_q == DOOR);
  assign bus.floor     = floor_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
